mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between the fetch stage (I port) and the

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals around the shared-memory arbiter.
// The arbiter uses the master modport; the pipeline/memory environment uses slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_ready, if_rdata,
    output d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_ready, if_rdata,
    input  d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch (I) and load/store (D) requests onto one fixed-latency single-port memory.
// Define ARB_RR_EN for round-robin tie-breaking; default build gives D fixed priority over I.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              owner_r;
  logic              we_r;
  logic              grant_s;
  logic              sample_s;
  logic              pick_d_s;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              if_ready_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              d_ready_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              busy_r;

`ifdef ARB_RR_EN
  logic              last_grant_r;
`endif

  // Owner selection for a grant taken in IDLE.
  always_comb begin
    pick_d_s = 1'b0;
    if (bus.d_req && bus.if_req) begin
`ifdef ARB_RR_EN
      pick_d_s = (last_grant_r == OWN_I);
`else
      pick_d_s = 1'b1;
`endif
    end else if (bus.d_req) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Next-state logic; the strobe cycle does not count so that count==1 marks valid read data.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    grant_s     = 1'b0;
    sample_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_s     = 1'b1;
          count_nxt_s = CNT_LOAD;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_en_r) begin
          count_nxt_s = count_r;
        end else if (count_r == CNT_ONE) begin
          sample_s    = 1'b1;
          count_nxt_s = count_r - CNT_ONE;
          state_nxt_s = ST_DONE;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Control state: FSM, latency counter and the owner/direction of the access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      owner_r <= OWN_I;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (grant_s) begin
        owner_r <= pick_d_s ? OWN_D : OWN_I;
        we_r    <= pick_d_s & bus.d_we;
      end
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history: remembers who won the most recent grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= OWN_I;
    end else if (grant_s) begin
      last_grant_r <= pick_d_s ? OWN_D : OWN_I;
    end
  end
`endif

  // Memory-side registers: single-cycle strobe, address/data latched at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_en_r <= grant_s;
      mem_we_r <= grant_s & pick_d_s & bus.d_we;
      if (grant_s) begin
        mem_addr_r <= pick_d_s ? bus.d_addr : bus.if_addr;
        if (pick_d_s) begin
          mem_wdata_r <= bus.d_wdata;
        end
      end
    end
  end

  // Port-side registers: ready pulses land in DONE, read data is held until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready_r <= 1'b0;
      if_rdata_r <= {DATA_W{1'b0}};
      d_ready_r  <= 1'b0;
      d_rdata_r  <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      if_ready_r <= sample_s & (owner_r == OWN_I);
      d_ready_r  <= sample_s & (owner_r == OWN_D);
      busy_r     <= (state_nxt_s != ST_IDLE);
      if (sample_s && (owner_r == OWN_I)) begin
        if_rdata_r <= bus.mem_rdata;
      end
      // Stores complete with a pulse but leave the load result untouched.
      if (sample_s && (owner_r == OWN_D) && !we_r) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected accesses, fixed-latency memory model,
// per-cycle monitor on the falling edge.
module tb_mem_arbiter;
  localparam int LAT = 2;
  localparam int P   = LAT + 3;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t_grant;
  } item_t;

  item_t       sb[$];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_en    = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_d_rdata  = 32'h0;

  logic [31:0] mem_model [256];
  bit          wr_v      [256];
  logic [31:0] ref_mem   [256];
  bit          ref_v     [256];
  logic [31:0] pipe      [LAT];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
  endfunction

  // Memory model: writes on strobe, read data appears LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en && bus.mem_we) begin
      mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
      wr_v[bus.mem_addr[9:2]]      <= 1'b1;
    end
    pipe[0] <= bus.mem_en ? (wr_v[bus.mem_addr[9:2]] ? mem_model[bus.mem_addr[9:2]]
                                                      : dflt(bus.mem_addr))
                          : (32'hBAD0_0000 ^ 32'(cyc));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input int tg);
    item_t it;
    it.port_d  = d;
    it.we      = we;
    it.addr    = a;
    it.wdata   = wd;
    it.t_grant = tg;
    it.rdata   = we ? 32'h0 : (ref_v[a[9:2]] ? ref_mem[a[9:2]] : dflt(a));
    if (we) begin
      ref_mem[a[9:2]] = wd;
      ref_v[a[9:2]]   = 1'b1;
    end
    sb.push_back(it);
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check1(tag, (sb.size() == 0) && !bus.busy, 1'b1);
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    check1({tag, "_mem_en"}, bus.mem_en, 1'b0);
    check1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    check32({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    check32({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    check1({tag, "_if_ready"}, bus.if_ready, 1'b0);
    check32({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    check1({tag, "_d_ready"}, bus.d_ready, 1'b0);
    check32({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    check1({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // Monitor: every cycle compares strobe, busy, ready pulses and held read data to the scoreboard head.
  always @(negedge clk) begin
    item_t h;
    bit    have;
    bit    exp_en;
    bit    exp_busy;
    bit    exp_rdy;
    if (mon_en && reset) begin
      have = (sb.size() > 0);
      if (have) h = sb[0];
      exp_en   = have && (cyc == h.t_grant + 1);
      exp_busy = have && (cyc >= h.t_grant + 1) && (cyc <= h.t_grant + LAT + 2);
      exp_rdy  = have && (cyc == h.t_grant + LAT + 2);
      if (bus.mem_en) n_en++;
      check1("busy", bus.busy, exp_busy);
      check1("mem_en", bus.mem_en, exp_en);
      if (exp_en) begin
        check32("mem_addr", bus.mem_addr, h.addr);
        check1("mem_we", bus.mem_we, h.we);
        if (h.we) check32("mem_wdata", bus.mem_wdata, h.wdata);
      end else begin
        check1("mem_we_idle", bus.mem_we, 1'b0);
      end
      check1("if_ready", bus.if_ready, exp_rdy && !h.port_d);
      check1("d_ready", bus.d_ready, exp_rdy && h.port_d);
      if (exp_rdy) begin
        if (!h.port_d) exp_if_rdata = h.rdata;
        else if (!h.we) exp_d_rdata = h.rdata;
        void'(sb.pop_front());
      end
      check32("if_rdata", bus.if_rdata, exp_if_rdata);
      check32("d_rdata", bus.d_rdata, exp_d_rdata);
    end
  end

  initial begin
    int t;
    int e0;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'h0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle");

    // 1: single fetch
    t = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    push(1'b0, 1'b0, 32'h10, 32'h0, t);
    to_cycle(t + 1);
    bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFF0;
    drain("t1_drain");

    // 2: simultaneous requests, D first then I
    t = cyc;
    bus.d_req = 1'b1; bus.d_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    push(1'b1, 1'b0, 32'h40, 32'h0, t);
    push(1'b0, 1'b0, 32'h10, 32'h0, t + P);
    to_cycle(t + 1);
    bus.d_req = 1'b0; bus.d_addr = 32'h0;
    to_cycle(t + P + 1);
    bus.if_req = 1'b0;
    drain("t2_drain");

    // 3: store, then load back the stored word
    t = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    push(1'b1, 1'b1, 32'h20, 32'h1234_5678, t);
    to_cycle(t + 1);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0;
    drain("t3_store_drain");
    t = cyc;
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    push(1'b1, 1'b0, 32'h20, 32'h0, t);
    to_cycle(t + 1);
    bus.d_req = 1'b0;
    drain("t3_load_drain");

    // 4: reset in the middle of a fetch, request kept high across it
    t = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    push(1'b0, 1'b0, 32'h30, 32'h0, t);
    to_cycle(t + 2);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    sb.delete();
    exp_if_rdata = 32'h0;
    exp_d_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    t = cyc;
    reset = 1'b1;
    push(1'b0, 1'b0, 32'h30, 32'h0, t);
    to_cycle(t + 1);
    bus.if_req = 1'b0;
    drain("t4_drain");

    // 5a: request held through DONE only -> one access
    t = cyc; e0 = n_en;
    bus.if_req = 1'b1; bus.if_addr = 32'h50;
    push(1'b0, 1'b0, 32'h50, 32'h0, t);
    to_cycle(t + LAT + 2);
    bus.if_req = 1'b0;
    drain("t5a_drain");
    check32("t5a_access_count", 32'(n_en - e0), 32'd1);

    // 5b: request held two cycles past ready -> two accesses
    t = cyc; e0 = n_en;
    bus.if_req = 1'b1; bus.if_addr = 32'h60;
    push(1'b0, 1'b0, 32'h60, 32'h0, t);
    push(1'b0, 1'b0, 32'h60, 32'h0, t + P);
    to_cycle(t + LAT + 4);
    bus.if_req = 1'b0;
    drain("t5b_drain");
    check32("t5b_access_count", 32'(n_en - e0), 32'd2);

    // 6: both requests held for five grants
    t = cyc; e0 = n_en;
    bus.d_req = 1'b1; bus.d_addr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_RR_EN
      if (k % 2 == 0) push(1'b1, 1'b0, 32'h200, 32'h0, t + k * P);
      else            push(1'b0, 1'b0, 32'h100, 32'h0, t + k * P);
`else
      push(1'b1, 1'b0, 32'h200, 32'h0, t + k * P);
`endif
    end
    to_cycle(t + 4 * P + LAT + 2);
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    drain("t6_drain");
    check32("t6_access_count", 32'(n_en - e0), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
